// File: rtl/lc3b_muldiv.sv
// lc3b_muldiv: iterative multiply/divide unit that sits beside the LC-3b ALU.
// Each clock produces one bit (shift-add multiply, restoring divide); a final cycle fixes up the signs.
module lc3b_muldiv #(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             div_by_zero
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]   ZERO_CNT = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]   ONE_CNT  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH - 1);

   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
      return ~v + ONE_W;
   endfunction

   state_t             state_r, next_state_s;
   logic [1:0]         op_r;
   logic               sa_r, sb_r;
   logic [WIDTH-1:0]   opnd_r;
   logic [2*WIDTH-1:0] acc_r;
   logic [CNT_W-1:0]   cnt_r;

   logic               busy_r, done_r, dbz_r;
   logic [WIDTH-1:0]   lo_r, hi_r;
   logic               busy_s, done_s, dbz_s;
   logic [WIDTH-1:0]   lo_s, hi_s;

   logic [WIDTH-1:0]   mag_a_s, mag_b_s;
   logic               dbz_start_s;
   logic [WIDTH:0]     mul_add_s, div_shl_s, div_diff_s;
   logic               q_bit_s;
   logic [WIDTH-1:0]   new_rem_s;
   logic [2*WIDTH-1:0] mul_next_s, div_next_s, prod_neg_s;
   logic [WIDTH-1:0]   fix_lo_s, fix_hi_s;

   // Operand magnitudes at request time; signed modes take |x| as an unsigned value.
   always_comb begin
      mag_a_s     = (op[0] && a[WIDTH-1]) ? neg_w(a) : a;
      mag_b_s     = (op[0] && b[WIDTH-1]) ? neg_w(b) : b;
      dbz_start_s = start && op[1] && (b == ZERO_W);
   end

   // One iteration step: the multiplier shifts out of acc low half, the dividend shifts into the remainder.
   always_comb begin
      mul_add_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
      mul_next_s = {mul_add_s, acc_r[WIDTH-1:1]};
      div_shl_s  = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
      div_diff_s = div_shl_s - {1'b0, opnd_r};
      q_bit_s    = ~div_diff_s[WIDTH];
      new_rem_s  = q_bit_s ? div_diff_s[WIDTH-1:0] : div_shl_s[WIDTH-1:0];
      div_next_s = {new_rem_s, acc_r[WIDTH-2:0], q_bit_s};
   end

   // Sign fix-up applied when leaving FIX.
   always_comb begin
      prod_neg_s = ~acc_r + ONE_2W;
      fix_lo_s   = acc_r[WIDTH-1:0];
      fix_hi_s   = acc_r[2*WIDTH-1:WIDTH];
      case (op_r)
         2'b01: begin
            if (sa_r ^ sb_r) begin
               fix_lo_s = prod_neg_s[WIDTH-1:0];
               fix_hi_s = prod_neg_s[2*WIDTH-1:WIDTH];
            end else begin
               fix_lo_s = acc_r[WIDTH-1:0];
               fix_hi_s = acc_r[2*WIDTH-1:WIDTH];
            end
         end
         2'b11: begin
            fix_lo_s = (sa_r ^ sb_r) ? neg_w(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
            fix_hi_s = sa_r ? neg_w(acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
         end
         default: begin
            fix_lo_s = acc_r[WIDTH-1:0];
            fix_hi_s = acc_r[2*WIDTH-1:WIDTH];
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= IDLE;
      else        state_r <= next_state_s;
   end

   // Next-state logic; flush only aborts work in progress.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (dbz_start_s) next_state_s = DONE;
            else if (start)  next_state_s = CALC;
            else             next_state_s = IDLE;
         end
         CALC: begin
            if (flush)                  next_state_s = IDLE;
            else if (cnt_r == LAST_CNT) next_state_s = FIX;
            else                        next_state_s = CALC;
         end
         FIX: begin
            if (flush) next_state_s = IDLE;
            else       next_state_s = DONE;
         end
         DONE:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // Output next values; results hold except on a completed op or an immediate divide-by-zero.
   always_comb begin
      busy_s = (next_state_s != IDLE);
      done_s = 1'b0;
      lo_s   = lo_r;
      hi_s   = hi_r;
      dbz_s  = dbz_r;
      case (state_r)
         IDLE: begin
            if (dbz_start_s) begin
               done_s = 1'b1;
               lo_s   = ONES_W;
               hi_s   = a;
               dbz_s  = 1'b1;
            end else begin
               done_s = 1'b0;
            end
         end
         FIX: begin
            if (!flush) begin
               done_s = 1'b1;
               lo_s   = fix_lo_s;
               hi_s   = fix_hi_s;
               dbz_s  = 1'b0;
            end else begin
               done_s = 1'b0;
            end
         end
         default: done_s = 1'b0;
      endcase
   end

   // Registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
         lo_r   <= ZERO_W;
         hi_r   <= ZERO_W;
         dbz_r  <= 1'b0;
      end else begin
         busy_r <= busy_s;
         done_r <= done_s;
         lo_r   <= lo_s;
         hi_r   <= hi_s;
         dbz_r  <= dbz_s;
      end
   end

   // Operand latch at start and iteration datapath during CALC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r   <= 2'b00;
         sa_r   <= 1'b0;
         sb_r   <= 1'b0;
         opnd_r <= ZERO_W;
         acc_r  <= {(2*WIDTH){1'b0}};
         cnt_r  <= ZERO_CNT;
      end else if (state_r == IDLE && start) begin
         op_r   <= op;
         sa_r   <= op[0] & a[WIDTH-1];
         sb_r   <= op[0] & b[WIDTH-1];
         opnd_r <= op[1] ? mag_b_s : mag_a_s;
         acc_r  <= op[1] ? {ZERO_W, mag_a_s} : {ZERO_W, mag_b_s};
         cnt_r  <= ZERO_CNT;
      end else if (state_r == CALC) begin
         acc_r  <= op_r[1] ? div_next_s : mul_next_s;
         cnt_r  <= cnt_r + ONE_CNT;
      end else begin
         acc_r  <= acc_r;
         cnt_r  <= cnt_r;
      end
   end

   assign busy        = busy_r;
   assign done        = done_r;
   assign result_lo   = lo_r;
   assign result_hi   = hi_r;
   assign div_by_zero = dbz_r;

endmodule
